// File: rtl/pwm_decoder.sv
// Decodes one transducer PWM line into pulse width and centre phase by
// timestamping its edges against the free-running 512-count carrier counter.
module pwm_decoder #(
  parameter int CNT_LATENCY = 1,
  parameter int T           = 512
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [8:0] TIME_CNT,
  input  logic       PWM_IN,
  output logic [8:0] PULSE_WIDTH,
  output logic [7:0] PHASE,
  output logic [8:0] RISE,
  output logic [8:0] FALL,
  output logic       GLITCH,
  output logic       STUCK_HIGH,
  output logic       STUCK_LOW,
  output logic       DOUT_VALID,
  output logic [7:0] DROP_CNT
);

  generate
    if (T != 512) begin : g_bad_period
      $error("pwm_decoder supports only T = 512");
    end
  endgenerate

  localparam logic [8:0] LAT = 9'(CNT_LATENCY);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [8:0] mod_sub(input logic [8:0] a, input logic [8:0] b);
    return a - b;
  endfunction

  // Centre = rise + width/2, wrapped to the period, reported in half-resolution.
  function automatic logic [7:0] centre_phase(input logic [8:0] r, input logic [8:0] pw);
    return 8'((r + {1'b0, pw[8:1]}) >> 1);
  endfunction

  // ---- stage 0: sample line and counter, keep previous sample ----
  logic       s_p0, s_d_p0;
  logic [8:0] t_p0, t_d_p0;
  logic       vld_p0, vld_d_p0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s_p0     <= 1'b0;
      s_d_p0   <= 1'b0;
      t_p0     <= 9'd0;
      t_d_p0   <= 9'd0;
      vld_p0   <= 1'b0;
      vld_d_p0 <= 1'b0;
    end else begin
      s_p0     <= PWM_IN;
      s_d_p0   <= s_p0;
      t_p0     <= TIME_CNT;
      t_d_p0   <= t_p0;
      vld_p0   <= 1'b1;
      vld_d_p0 <= vld_p0;
    end
  end

  logic       rise_p0, fall_p0, disc_p0, last_p0;
  logic [8:0] ts_p0;

  assign rise_p0 = vld_d_p0 & s_p0 & ~s_d_p0;
  assign fall_p0 = vld_d_p0 & ~s_p0 & s_d_p0;
  assign ts_p0   = mod_sub(t_p0, LAT);
  assign disc_p0 = vld_d_p0 & (t_p0 != t_d_p0 + 9'd1);
  assign last_p0 = vld_p0 & (t_p0 == 9'd511);

  state_t state_q, state_d;
  logic   acc_en, close_p0, dout_valid;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= SYNC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    if (!disc_p0 && last_p0) state_d = MEASURE;
      MEASURE: begin
        if (disc_p0)      state_d = SYNC;
        else if (last_p0) state_d = REPORT;
      end
      REPORT:  state_d = disc_p0 ? SYNC : MEASURE;
      default: state_d = SYNC;
    endcase
  end

  // REPORT also accumulates: its sample is the first one of the new window.
  always_comb begin
    dout_valid = (state_q == REPORT);
    acc_en     = (state_q == MEASURE) || (state_q == REPORT);
    close_p0   = (state_q == MEASURE) && last_p0 && !disc_p0;
  end

  // ---- stage 1: window accumulation (current sample merged combinationally) ----
  logic       have_r_p1, have_f_p1, glitch_p1;
  logic [8:0] r_p1, f_p1;
  logic       have_r_nx, have_f_nx, glitch_nx;
  logic [8:0] r_nx, f_nx;

  assign have_r_nx = have_r_p1 | rise_p0;
  assign have_f_nx = have_f_p1 | fall_p0;
  assign r_nx      = (rise_p0 && !have_r_p1) ? ts_p0 : r_p1;
  assign f_nx      = (fall_p0 && !have_f_p1) ? ts_p0 : f_p1;
  assign glitch_nx = glitch_p1 | (rise_p0 & have_r_p1) | (fall_p0 & have_f_p1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      have_r_p1 <= 1'b0;
      have_f_p1 <= 1'b0;
      glitch_p1 <= 1'b0;
      r_p1      <= 9'd0;
      f_p1      <= 9'd0;
    end else if (disc_p0 || !acc_en || close_p0) begin
      have_r_p1 <= 1'b0;
      have_f_p1 <= 1'b0;
      glitch_p1 <= 1'b0;
    end else begin
      have_r_p1 <= have_r_nx;
      have_f_p1 <= have_f_nx;
      glitch_p1 <= glitch_nx;
      r_p1      <= r_nx;
      f_p1      <= f_nx;
    end
  end

  // ---- stage 2: report computation and held outputs ----
  logic [8:0] pw_p2, rise_p2, fall_p2;
  logic [7:0] ph_p2, drop_p2;
  logic       gl_p2, sh_p2, sl_p2;
  logic [8:0] pw_c, rise_c, fall_c;
  logic [7:0] ph_c;
  logic       gl_c, sh_c, sl_c;

  always_comb begin
    pw_c   = 9'd0;
    ph_c   = 8'd0;
    rise_c = rise_p2;
    fall_c = fall_p2;
    gl_c   = 1'b0;
    sh_c   = 1'b0;
    sl_c   = 1'b0;
    if (have_r_nx && have_f_nx) begin
      pw_c   = mod_sub(f_nx, r_nx);
      ph_c   = centre_phase(r_nx, pw_c);
      rise_c = r_nx;
      fall_c = f_nx;
      gl_c   = glitch_nx;
    end else if (!have_r_nx && !have_f_nx) begin
      if (s_p0) begin
        pw_c = 9'd511;
        sh_c = 1'b1;
      end else begin
        sl_c = 1'b1;
      end
    end else begin
      gl_c = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pw_p2   <= 9'd0;
      ph_p2   <= 8'd0;
      rise_p2 <= 9'd0;
      fall_p2 <= 9'd0;
      gl_p2   <= 1'b0;
      sh_p2   <= 1'b0;
      sl_p2   <= 1'b0;
    end else if (close_p0) begin
      pw_p2   <= pw_c;
      ph_p2   <= ph_c;
      rise_p2 <= rise_c;
      fall_p2 <= fall_c;
      gl_p2   <= gl_c;
      sh_p2   <= sh_c;
      sl_p2   <= sl_c;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       drop_p2 <= 8'd0;
    else if (disc_p0) drop_p2 <= sat_inc(drop_p2);
  end

  assign PULSE_WIDTH = pw_p2;
  assign PHASE       = ph_p2;
  assign RISE        = rise_p2;
  assign FALL        = fall_p2;
  assign GLITCH      = gl_p2;
  assign STUCK_HIGH  = sh_p2;
  assign STUCK_LOW   = sl_p2;
  assign DOUT_VALID  = dout_valid;
  assign DROP_CNT    = drop_p2;

endmodule

// File: tb/tb_pwm_decoder.sv
// Self-checking bench for pwm_decoder: a waveform generator drives whole carrier
// periods, expected reports are queued and compared when DOUT_VALID fires.
module tb_pwm_decoder;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [8:0] TIME_CNT;
  logic       PWM_IN;
  logic [8:0] PULSE_WIDTH, RISE, FALL;
  logic [7:0] PHASE, DROP_CNT;
  logic       GLITCH, STUCK_HIGH, STUCK_LOW, DOUT_VALID;

  pwm_decoder #(.CNT_LATENCY(1), .T(512)) dut (
    .CLK(CLK), .RST_N(RST_N), .TIME_CNT(TIME_CNT), .PWM_IN(PWM_IN),
    .PULSE_WIDTH(PULSE_WIDTH), .PHASE(PHASE), .RISE(RISE), .FALL(FALL),
    .GLITCH(GLITCH), .STUCK_HIGH(STUCK_HIGH), .STUCK_LOW(STUCK_LOW),
    .DOUT_VALID(DOUT_VALID), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  localparam int K_PULSE  = 0;
  localparam int K_HIGH   = 1;
  localparam int K_LOW    = 2;
  localparam int K_DOUBLE = 3;

  typedef struct { int kind; int a; int b; int c; int d; } cfg_t;
  typedef struct { int pw; int ph; int rise; int fall; int gl; int sh; int sl; } res_t;
  typedef struct { cfg_t cfg; res_t exp; } vec_t;
  typedef struct { res_t exp; int due; } sb_t;

  sb_t  q[$];
  vec_t tbl[8];
  cfg_t prev_cfg, cfg_a;
  res_t exp_a;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Generator output at count n; the decoder sees it one clock later.
  function automatic logic wave(input cfg_t c, input int n);
    case (c.kind)
      K_HIGH:   return 1'b1;
      K_LOW:    return 1'b0;
      K_DOUBLE: return (n >= c.a && n < c.b) || (n >= c.c && n < c.d);
      default:  return ((n - c.a + 512) % 512) < ((c.b - c.a + 512) % 512);
    endcase
  endfunction

  task automatic drive(input int t, input logic lvl);
    @(posedge CLK);
    #1;
    TIME_CNT = 9'(t);
    PWM_IN   = lvl;
  endtask

  task automatic run_range(input cfg_t cur, input int lo, input int hi);
    for (int t = lo; t <= hi; t++)
      drive(t, (t == 0) ? wave(prev_cfg, 511) : wave(cur, t - 1));
  endtask

  task automatic run_period(input cfg_t cur, input res_t e);
    run_range(cur, 0, 511);
    q.push_back('{exp: e, due: cyc + 2});
    prev_cfg = cur;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pw"},    int'(PULSE_WIDTH), 0);
    check({tag, "_phase"}, int'(PHASE), 0);
    check({tag, "_rise"},  int'(RISE), 0);
    check({tag, "_fall"},  int'(FALL), 0);
    check({tag, "_glitch"}, int'(GLITCH), 0);
    check({tag, "_sh"},    int'(STUCK_HIGH), 0);
    check({tag, "_sl"},    int'(STUCK_LOW), 0);
    check({tag, "_valid"}, int'(DOUT_VALID), 0);
    check({tag, "_drop"},  int'(DROP_CNT), 0);
  endtask

  always @(negedge CLK) begin : monitor
    sb_t e;
    if (q.size() != 0 && cyc == q[0].due) begin
      e = q.pop_front();
      check("dout_valid", int'(DOUT_VALID), 1);
      check("pulse_width", int'(PULSE_WIDTH), e.exp.pw);
      check("phase", int'(PHASE), e.exp.ph);
      check("rise", int'(RISE), e.exp.rise);
      check("fall", int'(FALL), e.exp.fall);
      check("glitch", int'(GLITCH), e.exp.gl);
      check("stuck_high", int'(STUCK_HIGH), e.exp.sh);
      check("stuck_low", int'(STUCK_LOW), e.exp.sl);
    end else if (DOUT_VALID) begin
      check("unexpected_valid", int'(DOUT_VALID), 0);
    end
  end

  initial begin
    cfg_a = '{K_PULSE, 78, 178, 0, 0};
    exp_a = '{100, 64, 78, 178, 0, 0, 0};
    tbl[0] = '{cfg: cfg_a, exp: exp_a};
    tbl[1] = '{cfg: '{K_PULSE, 462, 51, 0, 0}, exp: '{51, 12, 0, 51, 1, 0, 0}};
    tbl[2] = '{cfg: '{K_PULSE, 462, 51, 0, 0}, exp: '{101, 0, 462, 51, 0, 0, 0}};
    tbl[3] = '{cfg: '{K_HIGH, 0, 0, 0, 0},     exp: '{511, 0, 462, 51, 0, 1, 0}};
    tbl[4] = '{cfg: '{K_LOW, 0, 0, 0, 0},      exp: '{0, 0, 462, 51, 1, 0, 0}};
    tbl[5] = '{cfg: '{K_LOW, 0, 0, 0, 0},      exp: '{0, 0, 462, 51, 0, 0, 1}};
    tbl[6] = '{cfg: '{K_DOUBLE, 10, 50, 300, 340}, exp: '{40, 15, 10, 50, 1, 0, 0}};
    tbl[7] = '{cfg: cfg_a, exp: exp_a};

    RST_N    = 1'b0;
    TIME_CNT = 9'd0;
    PWM_IN   = 1'b0;
    prev_cfg = cfg_a;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");

    // Release together with the first count so sampling starts contiguous.
    RST_N    = 1'b1;
    TIME_CNT = 9'd0;
    PWM_IN   = wave(cfg_a, 511);
    run_range(cfg_a, 1, 511);
    prev_cfg = cfg_a;

    for (int i = 0; i < 8; i++)
      run_period(tbl[i].cfg, tbl[i].exp);

    // Counter jump 200 -> 350: window dropped, next full period reported.
    run_range(cfg_a, 0, 200);
    run_range(cfg_a, 350, 511);
    prev_cfg = cfg_a;
    check("drop_after_jump", int'(DROP_CNT), 1);
    run_period(cfg_a, exp_a);

    // 300 consecutive discontinuities saturate the drop counter.
    for (int i = 1; i <= 300; i++)
      drive((2 * i) % 512, 1'b0);
    run_range(cfg_a, 89, 511);
    prev_cfg = cfg_a;
    check("drop_saturated", int'(DROP_CNT), 255);
    run_period(cfg_a, exp_a);

    // Asynchronous reset in the middle of a measured window.
    run_range(cfg_a, 0, 250);
    #3;
    RST_N = 1'b0;
    #2;
    check_all_zero("midreset");
    run_range(cfg_a, 251, 253);
    drive(254, wave(cfg_a, 253));
    RST_N = 1'b1;
    run_range(cfg_a, 255, 511);
    prev_cfg = cfg_a;
    run_period(cfg_a, exp_a);
    run_range(cfg_a, 0, 3);
    @(negedge CLK);
    check("reports_drained", q.size(), 0);
    check("drop_after_reset", int'(DROP_CNT), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
